// File: rtl/multicycle_alu.sv
// Purpose: ALU with single-cycle logic/arith ops and iterative shift-add multiply / restoring divide.
// Latency: ops 0-9 and 13-15 give done one cycle after start; ops 10-12 give done WIDTH+1 cycles after start.
// Backpressure: start is taken only while busy=0; a start during an iterative op is dropped.
module multicycle_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       aluOp,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             Zero,
  output logic             Sign
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_SLL  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_SLTU = 4'd6;
  localparam logic [3:0] OP_XOR  = 4'd7;
  localparam logic [3:0] OP_SRL  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd9;
  localparam logic [3:0] OP_MULU = 4'd10;
  localparam logic [3:0] OP_DIVU = 4'd11;
  localparam logic [3:0] OP_REMU = 4'd12;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_n;
  logic [SHW-1:0]   cnt;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] acc;     // product accumulator or partial remainder
  logic [WIDTH-1:0] opa;     // multiplicand shifting left, or dividend/quotient shift register
  logic [WIDTH-1:0] opb;     // multiplier shifting right, or fixed divisor

  logic             is_iter;
  logic             last;
  logic [WIDTH-1:0] quick;
  logic [WIDTH-1:0] mul_acc;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic             qbit;
  logic [WIDTH-1:0] rem_n;
  logic [WIDTH-1:0] quo_n;
  logic [WIDTH-1:0] iter_res;
  logic             load;
  logic [WIDTH-1:0] res_n;

  assign is_iter = (aluOp == OP_MULU) || (aluOp == OP_DIVU) || (aluOp == OP_REMU);
  assign last    = (cnt == SHW'(WIDTH - 1));
  assign busy    = (state == BUSY);
  assign done    = (state == DONE);

  // Single-cycle operations straight from the live operands; illegal codes give zero.
  always_comb begin
    quick = '0;
    case (aluOp)
      OP_ADD:  quick = A + B;
      OP_SUB:  quick = A - B;
      OP_AND:  quick = A & B;
      OP_OR:   quick = A | B;
      OP_SLL:  quick = B << A[SHW-1:0];
      OP_SLT:  quick = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLTU: quick = {{(WIDTH-1){1'b0}}, (A < B)};
      OP_XOR:  quick = A ^ B;
      OP_SRL:  quick = B >> A[SHW-1:0];
      OP_SRA:  quick = $signed(B) >>> A[SHW-1:0];
      default: quick = '0;
    endcase
  end

  // One iteration step: multiply adds one partial product, divide retires one quotient bit.
  // A zero divisor never borrows, so the quotient fills with ones and the remainder ends as A.
  always_comb begin
    mul_acc = acc + (opb[0] ? opa : '0);
    rem_sh  = {acc, opa[WIDTH-1]};
    diff    = rem_sh - {1'b0, opb};
    qbit    = ~diff[WIDTH];
    rem_n   = qbit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    quo_n   = {opa[WIDTH-2:0], qbit};
    case (op_q)
      OP_MULU: iter_res = mul_acc;
      OP_DIVU: iter_res = quo_n;
      default: iter_res = rem_n;
    endcase
  end

  // Next-state and result-load decision; DONE accepts a new start with no bubble.
  always_comb begin
    state_n = state;
    load    = 1'b0;
    res_n   = '0;
    case (state)
      IDLE, DONE: begin
        state_n = IDLE;
        if (start) begin
          if (is_iter) begin
            state_n = BUSY;
          end else begin
            state_n = DONE;
            load    = 1'b1;
            res_n   = quick;
          end
        end
      end
      BUSY: begin
        if (last) begin
          state_n = DONE;
          load    = 1'b1;
          res_n   = iter_res;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State register; reset wins over everything and aborts a running iteration.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Operand latching, iteration registers and the held result/flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      op_q   <= '0;
      acc    <= '0;
      opa    <= '0;
      opb    <= '0;
      result <= '0;
      Zero   <= 1'b1;
      Sign   <= 1'b0;
    end else begin
      if (load) begin
        result <= res_n;
        Zero   <= (res_n == '0);
        Sign   <= res_n[WIDTH-1];
      end
      if (state != BUSY && start && is_iter) begin
        op_q <= aluOp;
        opa  <= A;
        opb  <= B;
        acc  <= '0;
        cnt  <= '0;
      end else if (state == BUSY) begin
        cnt <= cnt + 1'b1;
        if (op_q == OP_MULU) begin
          acc <= mul_acc;
          opa <= opa << 1;
          opb <= opb >> 1;
        end else begin
          acc <= rem_n;
          opa <= quo_n;
        end
      end
    end
  end

endmodule

// File: tb/tb_multicycle_alu.sv
module tb_multicycle_alu;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [3:0]   aluOp;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         Zero;
  logic         Sign;

  int n_chk = 0;
  int n_bad = 0;

  multicycle_alu #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .aluOp  (aluOp),
    .A      (A),
    .B      (B),
    .busy   (busy),
    .done   (done),
    .result (result),
    .Zero   (Zero),
    .Sign   (Sign)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain arithmetic on the operation definitions.
  function automatic logic [W-1:0] ref_alu(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int unsigned      sh;
    logic [2*W-1:0]   p;
    sh = a % W;
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return b << sh;
      4'd5:  return ($signed(a) < $signed(b)) ? 1 : 0;
      4'd6:  return (a < b) ? 1 : 0;
      4'd7:  return a ^ b;
      4'd8:  return b >> sh;
      4'd9:  return b[W-1] ? ~((~b) >> sh) : (b >> sh);
      4'd10: begin p = a * b; return p[W-1:0]; end
      4'd11: return (b == 0) ? {W{1'b1}} : a / b;
      4'd12: return (b == 0) ? a : a % b;
      default: return '0;
    endcase
  endfunction

  // Issue one op from an idle DUT, scramble inputs while it runs, check timing and outputs.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] exp;
    int lat, nbusy, cyc, bcnt;
    exp   = ref_alu(op, a, b);
    lat   = (op >= 10 && op <= 12) ? W + 1 : 1;
    nbusy = (op >= 10 && op <= 12) ? W : 0;
    start = 1'b1; aluOp = op; A = a; B = b;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1; bcnt = 0;
    while (!done && cyc < W + 10) begin
      if (busy) bcnt++;
      A = $urandom; B = $urandom; aluOp = 4'($urandom);
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "/lat"},   cyc, lat);
    check({tag, "/nbusy"}, bcnt, nbusy);
    check({tag, "/busy"},  busy, 1'b0);
    check({tag, "/res"},   result, exp);
    check({tag, "/zero"},  Zero, (exp == 0));
    check({tag, "/sign"},  Sign, exp[W-1]);
    @(posedge clk); #1;
    check({tag, "/done1"}, done, 1'b0);
    check({tag, "/hold"},  result, exp);
  endtask

  initial begin
    logic [W-1:0] ea, eb, esum, got;
    int dcount, dcyc;

    reset = 1'b1; start = 1'b0; aluOp = '0; A = '0; B = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst/busy", busy, 1'b0);
    check("rst/done", done, 1'b0);
    check("rst/res",  result, 0);
    check("rst/zero", Zero, 1'b1);
    check("rst/sign", Sign, 1'b0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed cases
    run_op("add_wrap", 4'd0,  32'hFFFF_FFFF, 32'h1);
    run_op("slt",      4'd5,  32'hFFFF_FFFE, 32'h1);
    run_op("sltu",     4'd6,  32'hFFFF_FFFE, 32'h1);
    run_op("sra",      4'd9,  32'h4,         32'h8000_0000);
    run_op("mulu",     4'd10, 32'h12345,     32'h10);
    run_op("divu",     4'd11, 32'd100,       32'd7);
    run_op("remu",     4'd12, 32'd100,       32'd7);
    run_op("divu0",    4'd11, 32'd100,       32'd0);
    run_op("remu0",    4'd12, 32'd9,         32'd0);
    run_op("illegal",  4'd14, 32'h5,         32'h7);
    run_op("sll",      4'd4,  32'h23,        32'h1);
    run_op("mulmax",   4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // Random ops, with small divisors mixed in
    for (int i = 0; i < 40; i++) begin
      logic [3:0]   op;
      logic [W-1:0] ra, rb;
      op = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = (i % 3 == 0) ? W'($urandom_range(0, 20)) : W'($urandom);
      run_op("rand", op, ra, rb);
    end

    // Start during BUSY is ignored
    start = 1'b1; aluOp = 4'd10; A = 32'h12345; B = 32'h10;
    @(posedge clk); #1;
    start = 1'b0; dcount = 0; dcyc = 0; got = '0;
    for (int cyc = 1; cyc <= W + 4; cyc++) begin
      if (done) begin dcount++; dcyc = cyc; got = result; end
      if (cyc == 5) begin start = 1'b1; aluOp = 4'd0; A = 32'h1; B = 32'h2; end
      else start = 1'b0;
      @(posedge clk); #1;
    end
    start = 1'b0;
    check("ign/count", dcount, 1);
    check("ign/cyc",   dcyc, W + 1);
    check("ign/res",   got, 32'h123450);

    // Reset during BUSY aborts with no done
    start = 1'b1; aluOp = 4'd10; A = 32'h7; B = 32'h9;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 1; cyc < 10; cyc++) begin
      @(posedge clk); #1;
    end
    check("abort/pre_busy", busy, 1'b1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort/busy", busy, 1'b0);
    check("abort/done", done, 1'b0);
    check("abort/res",  result, 0);
    check("abort/zero", Zero, 1'b1);
    dcount = 0;
    for (int cyc = 0; cyc < W + 8; cyc++) begin
      @(posedge clk); #1;
      if (done) dcount++;
    end
    check("abort/nodone", dcount, 0);

    // Back-to-back: start held high, one done per cycle
    ea = $urandom; eb = $urandom;
    start = 1'b1; aluOp = 4'd0; A = ea; B = eb;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      esum = ea + eb;
      check("b2b/done", done, 1'b1);
      check("b2b/res",  result, esum);
      ea = $urandom; eb = $urandom; A = ea; B = eb;
    end
    start = 1'b0;
    @(posedge clk); #1;
    check("b2b/end", done, 1'b0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
